aes_dec: RTL and testbench

AES_DEC -- requirements
Module: aes_dec

---
 rtl/aes_pkg.sv | 73 +++++++
 rtl/aes_inv_round.sv | 48 ++++
 rtl/aes_dec.sv | 111 +++++++++++
 tb/tb_aes_dec.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ------------------------------------------------------------------------
// aes_pkg : shared AES tables, GF(2^8) helpers and types, rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

    localparam int NR_AES128 = 10;

    // Byte 0 of a block sits in bits [127:120]; byte i is row i%4, column i/4.
    typedef logic [0:15][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } key_state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Indexed by round number 1..10; the unused slots read as zero.
    localparam logic [0:15][7:0] RCON = 128'h0001020408102040801b360000000000;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {SBOX[w3[23:16]] ^ rc, SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_round.sv
// ------------------------------------------------------------------------
// aes_inv_round : one combinational AES inverse round, rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module aes_inv_round
    import aes_pkg::*;
#(
    parameter bit LAST = 1'b0
) (
    input  state_t din,
    input  state_t round_key,
    output state_t dout
);

    state_t added;

    // InvShiftRows moves row r right by r columns, folded into the S-box lookup.
    always_comb begin
        added = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                added[4*c+r] = INV_SBOX[din[4*((c+4-r)%4)+r]] ^ round_key[4*c+r];
            end
        end
    end

    if (LAST) begin : g_last
        assign dout = added;
    end else begin : g_mix
        always_comb begin
            dout = '0;
            for (int c = 0; c < 4; c++) begin
                dout[4*c+0] = gmul(added[4*c], 8'd14) ^ gmul(added[4*c+1], 8'd11)
                            ^ gmul(added[4*c+2], 8'd13) ^ gmul(added[4*c+3], 8'd9);
                dout[4*c+1] = gmul(added[4*c], 8'd9)  ^ gmul(added[4*c+1], 8'd14)
                            ^ gmul(added[4*c+2], 8'd11) ^ gmul(added[4*c+3], 8'd13);
                dout[4*c+2] = gmul(added[4*c], 8'd13) ^ gmul(added[4*c+1], 8'd9)
                            ^ gmul(added[4*c+2], 8'd14) ^ gmul(added[4*c+3], 8'd11);
                dout[4*c+3] = gmul(added[4*c], 8'd11) ^ gmul(added[4*c+1], 8'd13)
                            ^ gmul(added[4*c+2], 8'd9)  ^ gmul(added[4*c+3], 8'd14);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_dec.sv
// ------------------------------------------------------------------------
// aes_dec : 10-stage pipelined AES-128 decryptor with key FSM, rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module aes_dec
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] IN,
    input  logic [127:0] KEY,
    input  logic         enable,
    input  logic         fsm_en,
    output logic [127:0] OUT,
    output logic         out_valid,
    output logic         key_ready
);

    if (NR != NR_AES128) begin : g_nr_check
        $error("aes_dec: only NR=10 (AES-128) is supported");
    end

    key_state_t   state;
    key_state_t   state_next;
    logic [3:0]   round_cnt;
    state_t       rk [0:10];
    logic [127:0] key_cur;
    logic [127:0] key_next;

    state_t       stage [0:9];
    state_t       round_out [1:10];
    logic [10:0]  valid;
    logic         accept;

    assign key_next  = expand_key(key_cur, RCON[round_cnt]);
    assign key_ready = (state == READY);
    assign accept    = enable & key_ready & ~fsm_en;
    assign out_valid = valid[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (fsm_en) begin
            state_next = EXPAND;
        end else begin
            case (state)
                EXPAND:  if (round_cnt == 4'd10) state_next = READY;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_cnt <= 4'd0;
        end else if (fsm_en) begin
            round_cnt <= 4'd1;
        end else if (state == EXPAND && round_cnt != 4'd10) begin
            round_cnt <= round_cnt + 4'd1;
        end
    end

    // key_cur tracks the latest round key so expansion needs no read mux over rk.
    always_ff @(posedge clk) begin
        if (fsm_en) begin
            rk[0]   <= KEY;
            key_cur <= KEY;
        end else if (state == EXPAND) begin
            rk[round_cnt] <= key_next;
            key_cur       <= key_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        valid <= '0;
        else if (fsm_en) valid <= '0;
        else             valid <= {valid[9:0], accept};
    end

    always_ff @(posedge clk) begin
        stage[0] <= IN ^ rk[10];
        for (int r = 1; r < 10; r++) begin
            stage[r] <= round_out[r];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      OUT <= '0;
        else if (valid[9] && !fsm_en)  OUT <= round_out[10];
    end

    for (genvar r = 1; r <= 10; r++) begin : g_round
        aes_inv_round #(
            .LAST (r == NR_AES128)
        ) u_round (
            .din       (stage[r-1]),
            .round_key (rk[10-r]),
            .dout      (round_out[r])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_dec.sv
// ------------------------------------------------------------------------
// tb_aes_dec : scoreboard bench for aes_dec using FIPS-197 / SP800-38A vectors, rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_aes_dec;

    localparam logic [127:0] K1    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CA    = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PA    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CB    = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] PB    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CF    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PF    = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] IN;
    logic [127:0] KEY;
    logic         enable;
    logic         fsm_en;
    logic [127:0] OUT;
    logic         out_valid;
    logic         key_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    aes_dec #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .IN        (IN),
        .KEY       (KEY),
        .enable    (enable),
        .fsm_en    (fsm_en),
        .OUT       (OUT),
        .out_valid (out_valid),
        .key_ready (key_ready)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every out_valid must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: out_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                e = sb.pop_front();
                check("plaintext", OUT, e.data);
                check("latency_cycle", 128'(cyc), 128'(e.due));
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            checks++;
            errors++;
            $display("FAIL missing_output: no out_valid by cycle %0d, required at %0d", cyc, sb[0].due);
            void'(sb.pop_front());
        end
    end

    task automatic load_key(input logic [127:0] k, input logic en_too);
        int n;
        @(negedge clk);
        KEY    = k;
        fsm_en = 1'b1;
        enable = en_too;
        @(posedge clk);
        #1;
        fsm_en = 1'b0;
        KEY    = ~k;
        check("key_ready_after_start", 128'(key_ready), 128'(0));
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (key_ready) begin
                n = i;
                break;
            end
        end
        enable = 1'b0;
        check("key_ready_latency", 128'(n), 128'(10));
    endtask

    task automatic send(input logic [127:0] ct, input logic [127:0] pt, input logic expect_out);
        exp_t e;
        @(negedge clk);
        IN     = ct;
        enable = 1'b1;
        @(posedge clk);
        #1;
        if (expect_out) begin
            e.data = pt;
            e.due  = cyc + 10;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        enable = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int seen;
        enable = 1'b0;
        fsm_en = 1'b0;
        IN     = '0;
        KEY    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_key_ready", 128'(key_ready), 128'(0));
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_out", OUT, 128'h0);
        @(negedge clk);
        rst = 1'b1;

        // Enable while idle after reset is ignored.
        send(C1, P1, 1'b0);
        send(C1, P1, 1'b0);
        idle(2);

        load_key(K1, 1'b0);
        send(C1, P1, 1'b1);
        idle(15);

        load_key(K2, 1'b0);
        send(CA, PA, 1'b1);
        send(CB, PB, 1'b1);
        idle(15);

        // Enable alongside fsm_en and during expansion is dropped.
        load_key(K1, 1'b1);
        idle(20);
        check("out_held_after_drop", OUT, PB);

        // Re-key three cycles after an accepted block discards it.
        send(C1, P1, 1'b0);
        idle(2);
        load_key(K2, 1'b0);
        idle(12);
        check("out_held_after_discard", OUT, PB);
        send(CF, PF, 1'b1);
        idle(15);

        // Asynchronous reset while blocks are in flight.
        send(CA, PA, 1'b1);
        send(CB, PB, 1'b1);
        send(CF, PF, 1'b1);
        @(negedge clk);
        enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("first_output_before_reset", 128'(seen), 128'(1));
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_out_valid", 128'(out_valid), 128'(0));
        check("async_reset_key_ready", 128'(key_ready), 128'(0));
        check("async_reset_out", OUT, 128'h0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send(CA, PA, 1'b0);
        idle(30);
        check("idle_after_reset_key_ready", 128'(key_ready), 128'(0));
        check("out_zero_after_reset", OUT, 128'h0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected outputs left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
